// File: rtl/timer_array.sv
// rtl/timer_array.sv - multi-channel programmable interval timer with sticky maskable interrupts
module timer_array #(
    parameter int CH_BITS = 1,
    parameter int WIDTH   = 32,
    parameter int PSC_W   = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [CH_BITS+1:0]      Addr,
    input  logic [31:0]             Wd,
    input  logic                    We,
    output logic [31:0]             Rd,
    output logic                    IRQ,
    output logic [(2**CH_BITS)-1:0] IRQ_vec
);

    localparam int CHANNELS = 2 ** CH_BITS;

    localparam logic [1:0] WORD_CTRL   = 2'd0;
    localparam logic [1:0] WORD_PRESET = 2'd1;
    localparam logic [1:0] WORD_COUNT  = 2'd2;
    localparam logic [1:0] WORD_STATUS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10,
        ST_INT  = 2'b11
    } state_t;

    logic [CHANNELS-1:0] en_q, en_n;
    logic [CHANNELS-1:0] im_q, im_n;
    logic [CHANNELS-1:0] ir_q, ir_n;
    logic [1:0]          mode_q   [CHANNELS];
    logic [1:0]          mode_n   [CHANNELS];
    logic [PSC_W-1:0]    psc_q    [CHANNELS];
    logic [PSC_W-1:0]    psc_n    [CHANNELS];
    logic [PSC_W-1:0]    presc_q  [CHANNELS];
    logic [PSC_W-1:0]    presc_n  [CHANNELS];
    logic [WIDTH-1:0]    preset_q [CHANNELS];
    logic [WIDTH-1:0]    preset_n [CHANNELS];
    logic [WIDTH-1:0]    count_q  [CHANNELS];
    logic [WIDTH-1:0]    count_n  [CHANNELS];
    state_t              state_q  [CHANNELS];
    state_t              state_n  [CHANNELS];

    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] set_ir;
    logic [CH_BITS-1:0]  sel_ch;
    logic [1:0]          sel_word;

    assign sel_ch   = Addr[CH_BITS+1:2];
    assign sel_word = Addr[1:0];

    // The FSM always acts on the current register values; a same-edge
    // register write lands afterwards, so CTRL writes override hardware
    // auto-clear of Enable and take effect from the following edge.
    always_comb begin
        en_n   = en_q;
        im_n   = im_q;
        ir_n   = ir_q;
        wr_hit = '0;
        set_ir = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            mode_n[c]   = mode_q[c];
            psc_n[c]    = psc_q[c];
            presc_n[c]  = presc_q[c];
            preset_n[c] = preset_q[c];
            count_n[c]  = count_q[c];
            state_n[c]  = state_q[c];
            wr_hit[c]   = We && (sel_ch == CH_BITS'(c));

            case (state_q[c])
                ST_IDLE: begin
                    if (en_q[c]) begin
                        state_n[c] = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!en_q[c]) begin
                        state_n[c] = ST_IDLE;
                    end else begin
                        count_n[c] = preset_q[c];
                        presc_n[c] = '0;
                        if (preset_q[c] == '0) begin
                            set_ir[c]  = 1'b1;
                            state_n[c] = ST_INT;
                        end else begin
                            state_n[c] = ST_CNT;
                        end
                    end
                end
                ST_CNT: begin
                    if (!en_q[c]) begin
                        state_n[c] = ST_IDLE;
                    end else if (presc_q[c] == psc_q[c]) begin
                        presc_n[c] = '0;
                        count_n[c] = count_q[c] - WIDTH'(1);
                        if (count_q[c] == WIDTH'(1)) begin
                            set_ir[c]  = 1'b1;
                            state_n[c] = ST_INT;
                        end
                    end else begin
                        presc_n[c] = presc_q[c] + PSC_W'(1);
                    end
                end
                ST_INT: begin
                    if (mode_q[c] == 2'b00) begin
                        en_n[c]    = 1'b0;
                        state_n[c] = ST_IDLE;
                    end else begin
                        // Periodic reload; a zero preset parks here re-raising IR.
                        count_n[c] = preset_q[c];
                        presc_n[c] = '0;
                        if (preset_q[c] == '0) begin
                            set_ir[c]  = 1'b1;
                            state_n[c] = ST_INT;
                        end else begin
                            state_n[c] = ST_CNT;
                        end
                    end
                end
            endcase

            if (set_ir[c]) begin
                ir_n[c] = 1'b1;
            end else if (wr_hit[c] && (sel_word == WORD_STATUS) && Wd[0]) begin
                ir_n[c] = 1'b0;
            end

            if (wr_hit[c] && (sel_word == WORD_CTRL)) begin
                en_n[c]   = Wd[0];
                mode_n[c] = Wd[2:1];
                im_n[c]   = Wd[3];
                psc_n[c]  = Wd[8 +: PSC_W];
            end

            if (wr_hit[c] && (sel_word == WORD_PRESET)) begin
                preset_n[c] = Wd[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            en_q <= '0;
            im_q <= '0;
            ir_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                mode_q[c]   <= '0;
                psc_q[c]    <= '0;
                presc_q[c]  <= '0;
                preset_q[c] <= '0;
                count_q[c]  <= '0;
                state_q[c]  <= ST_IDLE;
            end
        end else begin
            en_q <= en_n;
            im_q <= im_n;
            ir_q <= ir_n;
            for (int c = 0; c < CHANNELS; c++) begin
                mode_q[c]   <= mode_n[c];
                psc_q[c]    <= psc_n[c];
                presc_q[c]  <= presc_n[c];
                preset_q[c] <= preset_n[c];
                count_q[c]  <= count_n[c];
                state_q[c]  <= state_n[c];
            end
        end
    end

    always_comb begin
        Rd = '0;
        case (sel_word)
            WORD_CTRL: begin
                Rd[0]          = en_q[sel_ch];
                Rd[2:1]        = mode_q[sel_ch];
                Rd[3]          = im_q[sel_ch];
                Rd[8 +: PSC_W] = psc_q[sel_ch];
            end
            WORD_PRESET: Rd[WIDTH-1:0] = preset_q[sel_ch];
            WORD_COUNT:  Rd[WIDTH-1:0] = count_q[sel_ch];
            WORD_STATUS: begin
                Rd[0]   = ir_q[sel_ch];
                Rd[2:1] = state_q[sel_ch];
            end
        endcase
    end

    assign IRQ_vec = ir_q & im_q;
    assign IRQ     = |IRQ_vec;

endmodule

// File: tb/tb_timer_array.sv
// tb/tb_timer_array.sv - randomized and directed check of timer_array against a behavioural model
module tb_timer_array;

    localparam int CH_BITS = 1;
    localparam int CH      = 2 ** CH_BITS;
    localparam int WIDTH   = 32;
    localparam int PSC_W   = 8;

    logic               Clk = 1'b0;
    logic               Reset;
    logic [CH_BITS+1:0] Addr;
    logic [31:0]        Wd;
    logic               We;
    logic [31:0]        Rd;
    logic               IRQ;
    logic [CH-1:0]      IRQ_vec;

    timer_array #(.CH_BITS(CH_BITS), .WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Addr    (Addr),
        .Wd      (Wd),
        .We      (We),
        .Rd      (Rd),
        .IRQ     (IRQ),
        .IRQ_vec (IRQ_vec)
    );

    always #20 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one record per channel; phase 0 idle, 1 load, 2 counting, 3 terminal.
    int unsigned m_en[CH], m_mode[CH], m_im[CH], m_psc[CH], m_preset[CH];
    int unsigned m_count[CH], m_ir[CH], m_phase[CH], m_div[CH];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_psc[c] = 0; m_preset[c] = 0;
            m_count[c] = 0; m_ir[c] = 0; m_phase[c] = 0; m_div[c] = 0;
        end
    endtask

    task automatic model_step(input bit we, input int addr, input int unsigned wd);
        int wch;
        int wword;
        wch   = addr / 4;
        wword = addr % 4;
        for (int c = 0; c < CH; c++) begin
            bit raise;
            bit reload;
            raise  = 0;
            reload = 0;
            if (m_phase[c] == 0) begin
                if (m_en[c] != 0) m_phase[c] = 1;
            end else if (m_phase[c] == 1) begin
                if (m_en[c] == 0) m_phase[c] = 0;
                else reload = 1;
            end else if (m_phase[c] == 2) begin
                if (m_en[c] == 0) begin
                    m_phase[c] = 0;
                end else if (m_div[c] != m_psc[c]) begin
                    m_div[c] = (m_div[c] + 1) % (1 << PSC_W);
                end else begin
                    m_div[c]   = 0;
                    m_count[c] = m_count[c] - 1;
                    if (m_count[c] == 0) begin
                        raise      = 1;
                        m_phase[c] = 3;
                    end
                end
            end else begin
                if (m_mode[c] == 0) begin
                    m_en[c]    = 0;
                    m_phase[c] = 0;
                end else begin
                    reload = 1;
                end
            end
            if (reload) begin
                m_count[c] = m_preset[c];
                m_div[c]   = 0;
                m_phase[c] = (m_preset[c] == 0) ? 3 : 2;
                raise      = (m_preset[c] == 0);
            end
            if (we && wch == c) begin
                if (wword == 0) begin
                    m_en[c]   = wd & 1;
                    m_mode[c] = (wd >> 1) & 3;
                    m_im[c]   = (wd >> 3) & 1;
                    m_psc[c]  = (wd >> 8) & ((1 << PSC_W) - 1);
                end else if (wword == 1) begin
                    m_preset[c] = wd;
                end else if (wword == 3 && (wd & 1) != 0) begin
                    m_ir[c] = 0;
                end
            end
            if (raise) m_ir[c] = 1;
        end
    endtask

    function automatic logic [31:0] model_rd(input int a);
        int c;
        c = a / 4;
        case (a % 4)
            0:       return (m_psc[c] << 8) | (m_im[c] << 3) | (m_mode[c] << 1) | m_en[c];
            1:       return m_preset[c];
            2:       return m_count[c];
            default: return (m_phase[c] << 1) | m_ir[c];
        endcase
    endfunction

    task automatic check_all(input string tag);
        logic [CH-1:0] v;
        v = '0;
        for (int a = 0; a < 4 * CH; a++) begin
            Addr = a[CH_BITS+1:0];
            #1;
            chk($sformatf("%s_rd%0d", tag, a), Rd, model_rd(a));
        end
        for (int c = 0; c < CH; c++) v[c] = (m_ir[c] & m_im[c]) != 0;
        chk({tag, "_vec"}, 32'(IRQ_vec), 32'(v));
        chk({tag, "_irq"}, 32'(IRQ), 32'(|v));
    endtask

    task automatic tick(input bit we, input int addr, input logic [31:0] wd, input string tag);
        We   = we;
        Addr = addr[CH_BITS+1:0];
        Wd   = wd;
        @(posedge Clk);
        model_step(we, addr, wd);
        #1;
        We = 1'b0;
        check_all(tag);
    endtask

    task automatic peek(input int a, output logic [31:0] v);
        Addr = a[CH_BITS+1:0];
        #1;
        v = Rd;
    endtask

    logic [31:0] v;

    initial begin
        Reset = 1'b1;
        We    = 1'b0;
        Addr  = '0;
        Wd    = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all("por");
        Reset = 1'b0;

        // Asynchronous reset in the middle of a count
        tick(1, 1, 100, "rst");
        tick(1, 0, 32'h9, "rst");
        repeat (20) tick(0, 0, 0, "rst");
        peek(2, v);
        chk("rst_pre_cnt", v, 32'd82);
        Reset = 1'b1;
        model_reset();
        #1;
        chk("rst_async_irq", 32'(IRQ), 32'd0);
        peek(2, v);
        chk("rst_async_cnt", v, 32'd0);
        check_all("rst_hold");
        Reset = 1'b0;

        // One-shot, PSC=0, PRESET=5
        tick(1, 1, 5, "os");
        tick(1, 0, 32'h9, "os");
        for (int k = 1; k <= 7; k++) begin
            tick(0, 0, 0, "os");
            peek(2, v);
            chk("os_cnt", v, (k < 2) ? 32'd0 : 32'(7 - k));
            chk("os_irq", 32'(IRQ), (k == 7) ? 32'd1 : 32'd0);
        end
        tick(0, 0, 0, "os");
        peek(0, v);
        chk("os_ctrl", v, 32'h8);
        peek(3, v);
        chk("os_status", v, 32'h1);
        tick(0, 0, 0, "os");
        peek(3, v);
        chk("os_sticky", v, 32'h1);
        tick(1, 3, 1, "os");
        chk("os_clr_irq", 32'(IRQ), 32'd0);

        // Periodic with prescale on channel 1: IR every 13 cycles
        tick(1, 5, 3, "per");
        tick(1, 4, 32'h30B, "per");
        for (int k = 1; k <= 27; k++) begin
            if (k == 15) tick(1, 7, 1, "per");
            else tick(0, 0, 0, "per");
            if (k == 13 || k == 26) chk("per_vec_lo", 32'(IRQ_vec), 32'd0);
            if (k == 14 || k == 27) chk("per_vec_hi", 32'(IRQ_vec), 32'h2);
            if (k == 15) begin
                peek(7, v);
                chk("per_clr", v & 32'h1, 32'd0);
            end
        end
        tick(1, 4, 0, "per");
        tick(1, 7, 1, "per");

        // Masked one-shot, then unmask without restart
        tick(1, 1, 2, "msk");
        tick(1, 0, 32'h1, "msk");
        repeat (4) tick(0, 0, 0, "msk");
        peek(3, v);
        chk("msk_ir", v & 32'h1, 32'd1);
        chk("msk_irq", 32'(IRQ), 32'd0);
        tick(0, 0, 0, "msk");
        tick(1, 0, 32'h8, "msk");
        chk("msk_unmask_irq", 32'(IRQ), 32'd1);
        peek(3, v);
        chk("msk_no_restart", v, 32'h1);
        tick(1, 3, 1, "msk");

        // Periodic PRESET=2: clear between periods, clear colliding with set
        tick(1, 1, 2, "sw");
        tick(1, 0, 32'hB, "sw");
        for (int k = 1; k <= 7; k++) begin
            if (k == 5 || k == 7) tick(1, 3, 1, "sw");
            else tick(0, 0, 0, "sw");
            peek(3, v);
            if (k == 4) chk("sw_set", v & 32'h1, 32'd1);
            if (k == 5) chk("sw_clr", v & 32'h1, 32'd0);
            if (k == 7) chk("sw_set_wins", v & 32'h1, 32'd1);
        end
        tick(1, 0, 0, "sw");
        tick(1, 3, 1, "sw");

        // Independence: hammer ch1 PRESET while ch0 counts 10
        tick(1, 1, 10, "ind");
        tick(1, 0, 32'h9, "ind");
        for (int k = 1; k <= 12; k++) begin
            tick(1, 5, $urandom, "ind");
            if (k == 11) chk("ind_irq_lo", 32'(IRQ), 32'd0);
            if (k == 12) chk("ind_irq_hi", 32'(IRQ), 32'd1);
        end
        tick(1, 3, 1, "ind");
        tick(1, 1, 0, "z");
        tick(1, 0, 32'h9, "z");
        tick(0, 0, 0, "z");
        peek(3, v);
        chk("z_load", v, 32'h2);
        tick(0, 0, 0, "z");
        peek(3, v);
        chk("z_int", v, 32'h7);
        tick(0, 0, 0, "z");
        peek(3, v);
        chk("z_idle", v, 32'h1);
        tick(1, 3, 1, "z");

        // Disable mid-count and re-enable
        tick(1, 1, 50, "dis");
        tick(1, 0, 32'h9, "dis");
        repeat (19) tick(0, 0, 0, "dis");
        tick(1, 0, 0, "dis");
        for (int k = 0; k < 2; k++) begin
            tick(0, 0, 0, "dis");
            peek(2, v);
            chk("dis_frozen", v, 32'd32);
            peek(3, v);
            chk("dis_status", v, 32'd0);
        end
        tick(1, 0, 32'h9, "dis");
        tick(0, 0, 0, "dis");
        tick(0, 0, 0, "dis");
        peek(2, v);
        chk("dis_reload", v, 32'd50);
        tick(1, 0, 0, "dis");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int a;
            logic [31:0] d;
            a = $urandom_range(0, 4 * CH - 1);
            d = $urandom;
            if (a % 4 == 0) d[15:8] = 8'($urandom_range(0, 3));
            if (a % 4 == 1) d = $urandom_range(0, 8);
            if ($urandom_range(0, 9) < 3) tick(1, a, d, "rnd");
            else tick(0, 0, 0, "rnd");
            if ($urandom_range(0, 399) == 0) begin
                Reset = 1'b1;
                model_reset();
                #1;
                check_all("rnd_rst");
                Reset = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
